// File: rtl/md_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class decode helpers
// for the multiply/divide issue controller.
package md_pkg;

  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MFHI  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;
  localparam logic [2:0] MD_RSVD  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_read(input logic [2:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles after a clear and flags the
// cycle whose increment brings the count up to TIMEOUT.
module md_watchdog #(
  parameter int TIMEOUT = 40,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/interlock controller in front of the Mul HI/LO unit: starts multiply
// and divide ops, stalls EX while Mul is busy, and serves MFHI/MFLO reads.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT = 40,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Op_Valid,
  input  logic [2:0]  Op_Code,
  input  logic [31:0] Op_B,
  input  logic        Flush,
  output logic        Stall,
  output logic        Rd_Valid,
  output logic [31:0] Rd_Data,
  output logic        MUL_Start,
  output logic        MUL_SelMD,
  output logic        MUL_Sign,
  output logic        MUL_SelHL,
  input  logic        MUL_Flag,
  input  logic [31:0] MUL_DC,
  output logic        Err_DivZero,
  output logic        Err_Timeout
);

  md_state_e   state_q, state_d;
  logic        start_q, start_d;
  logic        selmd_q, selmd_d;
  logic        sign_q, sign_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        divz_q, divz_d;
  logic        tmo_q, tmo_d;

  logic md_op, accept, div_zero, launch, wd_expired;

  assign md_op    = Op_Valid && (is_arith(Op_Code) || is_read(Op_Code));
  assign accept   = (state_q == ST_IDLE) && md_op && !Flush;
  assign div_zero = is_div(Op_Code) && (Op_B == '0);
  assign launch   = accept && is_arith(Op_Code) && !div_zero;

  // Stall ignores Flush so a flushed op in EX is never mistaken for accepted.
  assign Stall     = md_op && (state_q == ST_BUSY);
  assign MUL_SelHL = accept && (Op_Code == MD_MFHI);

  md_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_watchdog (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .clr_i     (launch),
    .en_i      (state_q == ST_BUSY),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    selmd_d    = selmd_q;
    sign_d     = sign_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    divz_d     = 1'b0;
    tmo_d      = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_read(Op_Code)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = MUL_DC;
          end else if (div_zero) begin
            divz_d = 1'b1;
          end else begin
            start_d = 1'b1;
            selmd_d = is_div(Op_Code);
            sign_d  = is_signed(Op_Code);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // A completion arriving on the expiry cycle still counts as success.
        if (MUL_Flag) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      selmd_q    <= 1'b0;
      sign_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      divz_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      selmd_q    <= selmd_d;
      sign_q     <= sign_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      divz_q     <= divz_d;
      tmo_q      <= tmo_d;
    end
  end

  assign MUL_Start   = start_q;
  assign MUL_SelMD   = selmd_q;
  assign MUL_Sign    = sign_q;
  assign Rd_Valid    = rd_valid_q;
  assign Rd_Data     = rd_data_q;
  assign Err_DivZero = divz_q;
  assign Err_Timeout = tmo_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural Mul model and a
// read-data scoreboard fed at issue time and drained on Rd_Valid.
module tb_md_issue_ctrl;
  import md_pkg::*;

  localparam int TIMEOUT = 40;
  localparam int MUL_LAT = 3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Op_Valid;
  logic [2:0]  Op_Code;
  logic [31:0] Op_B;
  logic        Flush;
  logic        Stall;
  logic        Rd_Valid;
  logic [31:0] Rd_Data;
  logic        MUL_Start;
  logic        MUL_SelMD;
  logic        MUL_Sign;
  logic        MUL_SelHL;
  logic        MUL_Flag = 1'b0;
  logic [31:0] MUL_DC;
  logic        Err_DivZero;
  logic        Err_Timeout;

  int assertCount = 0;
  int failCount   = 0;
  int startCount  = 0;
  logic [31:0] expQ[$];

  logic        expSelMD = 1'b0;
  logic        expSign  = 1'b0;
  logic        prevStart = 1'b0;

  // Mul model state
  logic [31:0] hiQ = '0, loQ = '0;
  logic [31:0] mA = '0, mB = '0, cA = '0, cB = '0;
  logic        cSelMD = 1'b0, cSign = 1'b0;
  logic        hang = 1'b0;
  int          mulCnt = 0;
  logic signed [63:0] sa, sb, sprod;
  logic [63:0] uprod;

  always #5 Clk = ~Clk;

  md_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Op_Valid    (Op_Valid),
    .Op_Code     (Op_Code),
    .Op_B        (Op_B),
    .Flush       (Flush),
    .Stall       (Stall),
    .Rd_Valid    (Rd_Valid),
    .Rd_Data     (Rd_Data),
    .MUL_Start   (MUL_Start),
    .MUL_SelMD   (MUL_SelMD),
    .MUL_Sign    (MUL_Sign),
    .MUL_SelHL   (MUL_SelHL),
    .MUL_Flag    (MUL_Flag),
    .MUL_DC      (MUL_DC),
    .Err_DivZero (Err_DivZero),
    .Err_Timeout (Err_Timeout)
  );

  assign MUL_DC = MUL_SelHL ? hiQ : loQ;

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [31:0] b, input logic f);
    @(posedge Clk);
    #1;
    Op_Valid = v;
    Op_Code  = c;
    Op_B     = b;
    Flush    = f;
  endtask

  // Mul samples Start on the negedge and raises Flag MUL_LAT negedges later,
  // updating HI/LO at the same moment.
  always @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mulCnt   = 0;
      MUL_Flag = 1'b0;
    end else begin
      MUL_Flag = 1'b0;
      if (mulCnt > 0) begin
        mulCnt--;
        if (mulCnt == 0 && !hang) begin
          if (!cSelMD) begin
            sa = {{32{cA[31]}}, cA};
            sb = {{32{cB[31]}}, cB};
            sprod = sa * sb;
            uprod = {32'b0, cA} * {32'b0, cB};
            {hiQ, loQ} = cSign ? sprod : uprod;
          end else if (cSign) begin
            loQ = $signed(cA) / $signed(cB);
            hiQ = $signed(cA) % $signed(cB);
          end else begin
            loQ = cA / cB;
            hiQ = cA % cB;
          end
          MUL_Flag = 1'b1;
        end
      end
      if (MUL_Start) begin
        mulCnt = MUL_LAT;
        cA     = mA;
        cB     = mB;
        cSelMD = MUL_SelMD;
        cSign  = MUL_Sign;
      end
    end
  end

  always @(negedge Clk) begin
    if (!Reset_n) begin
      prevStart = 1'b0;
    end else begin
      if (MUL_Start) begin
        startCount++;
        checkBit("start_width", prevStart, 1'b0);
        checkBit("start_selmd", MUL_SelMD, expSelMD);
        checkBit("start_sign", MUL_Sign, expSign);
      end
      prevStart = MUL_Start;
      if (Rd_Valid) begin
        if (expQ.size() == 0) begin
          checkBit("rd_valid_unexpected", Rd_Valid, 1'b0);
        end else begin
          checkWord("rd_data", Rd_Data, expQ.pop_front());
        end
      end
    end
  end

  task automatic arithOp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic selMD, input logic sign);
    expSelMD = selMD;
    expSign  = sign;
    mA = a;
    mB = b;
    applyStimulus(1'b1, code, b, 1'b0);
    @(negedge Clk);
    checkBit("arith_stall_idle", Stall, 1'b0);
  endtask

  task automatic readOp(input logic [2:0] code, input logic [31:0] expData, input int expStalls);
    int stalls = 0;
    bit done = 1'b0;
    applyStimulus(1'b1, code, '0, 1'b0);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge Clk);
      if (Stall) begin
        stalls++;
        checkBit("selmd_hold", MUL_SelMD, expSelMD);
        applyStimulus(1'b1, code, '0, 1'b0);
      end else begin
        checkBit("read_selhl", MUL_SelHL, code == MD_MFHI);
        expQ.push_back(expData);
        done = 1'b1;
      end
    end
    checkBit("read_accept", done, 1'b1);
    checkWord("read_stalls", stalls, expStalls);
    applyStimulus(1'b0, MD_NOP, '0, 1'b0);
  endtask

  typedef struct {
    logic        valid;
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        expSelHL;
    logic        expStart;
    logic        expSelMD;
    logic        expSign;
    logic        expDivZ;
    logic        expRdValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int startsBefore;

    // Entered with HI=1, LO=3 left by the DIV 7/2 sequence.
    vecs[0]  = '{1'b1, MD_NOP,   32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, MD_RSVD,  32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, MD_MFHI,  32'd0,  32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
    vecs[3]  = '{1'b1, MD_MFLO,  32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3};
    vecs[4]  = '{1'b1, MD_MFHI,  32'd0,  32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, MD_DIV,   32'd9,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, MD_DIVU,  32'd9,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, MD_MULT,  32'd2,  32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, MD_DIVU,  32'd20, 32'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, MD_MFLO,  32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4};
    vecs[10] = '{1'b1, MD_DIV,   32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, MD_MFHI,  32'd0,  32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[12] = '{1'b1, MD_MFLO,  32'd0,  32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFD};

    Reset_n  = 1'b0;
    Op_Valid = 1'b0;
    Op_Code  = MD_NOP;
    Op_B     = '0;
    Flush    = 1'b0;
    repeat (2) @(negedge Clk);
    checkBit("rst_stall", Stall, 1'b0);
    checkBit("rst_start", MUL_Start, 1'b0);
    checkBit("rst_selmd", MUL_SelMD, 1'b0);
    checkBit("rst_sign", MUL_Sign, 1'b0);
    checkBit("rst_selhl", MUL_SelHL, 1'b0);
    checkBit("rst_rd_valid", Rd_Valid, 1'b0);
    checkWord("rst_rd_data", Rd_Data, 32'h0);
    checkBit("rst_divzero", Err_DivZero, 1'b0);
    checkBit("rst_timeout", Err_Timeout, 1'b0);
    Reset_n = 1'b1;

    $display("[TB] signed MULT then MFLO/MFHI");
    arithOp(MD_MULT, 32'd3, 32'hFFFFFFFC, 1'b0, 1'b1);
    readOp(MD_MFLO, 32'hFFFFFFF4, MUL_LAT + 1);
    readOp(MD_MFHI, 32'hFFFFFFFF, 0);

    $display("[TB] MULTU then MFHI/MFLO");
    arithOp(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    readOp(MD_MFHI, 32'h00000001, MUL_LAT + 1);
    readOp(MD_MFLO, 32'hFFFFFFFE, 0);

    $display("[TB] DIV 7/2");
    arithOp(MD_DIV, 32'd7, 32'd2, 1'b1, 1'b1);
    readOp(MD_MFLO, 32'd3, MUL_LAT + 1);
    readOp(MD_MFHI, 32'd1, 0);

    $display("[TB] DIVU by zero");
    startsBefore = startCount;
    applyStimulus(1'b1, MD_DIVU, 32'd0, 1'b0);
    @(negedge Clk);
    checkBit("divz_stall", Stall, 1'b0);
    applyStimulus(1'b0, MD_NOP, '0, 1'b0);
    @(negedge Clk);
    checkBit("divz_pulse", Err_DivZero, 1'b1);
    checkBit("divz_no_start", MUL_Start, 1'b0);
    applyStimulus(1'b0, MD_NOP, '0, 1'b0);
    @(negedge Clk);
    checkBit("divz_pulse_end", Err_DivZero, 1'b0);
    readOp(MD_MFLO, 32'd3, 0);
    readOp(MD_MFHI, 32'd1, 0);
    checkWord("divz_start_count", startCount, startsBefore);

    $display("[TB] flushed MULT in IDLE");
    startsBefore = startCount;
    applyStimulus(1'b1, MD_MULT, 32'd5, 1'b1);
    @(negedge Clk);
    checkBit("flush_stall", Stall, 1'b0);
    applyStimulus(1'b0, MD_NOP, '0, 1'b0);
    @(negedge Clk);
    checkBit("flush_no_start", MUL_Start, 1'b0);
    readOp(MD_MFHI, 32'd1, 0);
    checkWord("flush_start_count", startCount, startsBefore);

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      expSelMD = vecs[i].expSelMD;
      expSign  = vecs[i].expSign;
      mA = vecs[i].a;
      mB = vecs[i].b;
      applyStimulus(vecs[i].valid, vecs[i].code, vecs[i].b, vecs[i].flush);
      @(negedge Clk);
      checkBit($sformatf("vec%0d_selhl", i), MUL_SelHL, vecs[i].expSelHL);
      checkBit($sformatf("vec%0d_stall", i), Stall, 1'b0);
      if (vecs[i].expRdValid) expQ.push_back(vecs[i].expData);
      applyStimulus(1'b0, MD_NOP, '0, 1'b0);
      @(negedge Clk);
      checkBit($sformatf("vec%0d_start", i), MUL_Start, vecs[i].expStart);
      checkBit($sformatf("vec%0d_divz", i), Err_DivZero, vecs[i].expDivZ);
      checkBit($sformatf("vec%0d_rd_valid", i), Rd_Valid, vecs[i].expRdValid);
      repeat (MUL_LAT + 3) applyStimulus(1'b0, MD_NOP, '0, 1'b0);
    end

    $display("[TB] NOP and flushed MFLO during BUSY");
    arithOp(MD_MULT, 32'd2, 32'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, MD_NOP, '0, 1'b0);
    @(negedge Clk);
    checkBit("busy_nop_stall", Stall, 1'b0);
    applyStimulus(1'b1, MD_RSVD, '0, 1'b0);
    @(negedge Clk);
    checkBit("busy_rsvd_stall", Stall, 1'b0);
    applyStimulus(1'b1, MD_MFLO, '0, 1'b1);
    @(negedge Clk);
    checkBit("busy_flush_stall", Stall, 1'b1);
    readOp(MD_MFLO, 32'd6, 1);

    $display("[TB] watchdog timeout");
    hang = 1'b1;
    arithOp(MD_MULT, 32'd1, 32'd1, 1'b0, 1'b1);
    checkBit("tmo_before", Err_Timeout, 1'b0);
    readOp(MD_MFLO, 32'd6, TIMEOUT);
    checkBit("tmo_set", Err_Timeout, 1'b1);
    repeat (5) applyStimulus(1'b0, MD_NOP, '0, 1'b0);
    @(negedge Clk);
    checkBit("tmo_sticky", Err_Timeout, 1'b1);
    hang = 1'b0;

    $display("[TB] reset during BUSY");
    arithOp(MD_DIV, 32'd9, 32'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, MD_MFLO, '0, 1'b0);
    @(negedge Clk);
    checkBit("rstbusy_stall1", Stall, 1'b1);
    applyStimulus(1'b1, MD_MFLO, '0, 1'b0);
    @(negedge Clk);
    checkBit("rstbusy_stall2", Stall, 1'b1);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    checkBit("rstbusy_stall", Stall, 1'b0);
    checkBit("rstbusy_start", MUL_Start, 1'b0);
    checkBit("rstbusy_rd_valid", Rd_Valid, 1'b0);
    checkBit("rstbusy_selmd", MUL_SelMD, 1'b0);
    checkBit("rstbusy_sign", MUL_Sign, 1'b0);
    checkBit("rstbusy_timeout", Err_Timeout, 1'b0);
    Op_Valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    arithOp(MD_MULT, 32'd4, 32'd5, 1'b0, 1'b1);
    readOp(MD_MFLO, 32'd20, MUL_LAT + 1);

    repeat (3) applyStimulus(1'b0, MD_NOP, '0, 1'b0);
    @(negedge Clk);
    checkWord("rd_queue_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
